tile_scheduler: RTL and testbench
=================================

TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 The block SHALL have parameter ADDRESS_SIZE, default 8, width of memory word addresses.
REQ-002 The block SHALL have parameter DIM_W, default 8, width of matrix dimension and index fields.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  launch request; sampled only in IDLE.
REQ-007 m_size, k_size, n_size  in  DIM_W each  A is m x k and B is k x n, in elements.
REQ-008 a_offset, b_offset, c_offset  in  ADDRESS_SIZE each  base addresses of row-major A, B and C.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 size_error  out  1  latched error flag for the last job.
REQ-012 tile_stb  out  1  tile command valid.
REQ-013 tile_ack  in  1  tile command accepted.
REQ-014 tile_row, tile_col, tile_k  out  DIM_W each  element indices of the tile origin; always multiples of 4.
REQ-015 rows_valid, cols_valid, k_valid  out  3 each  valid extent of the tile, 1..4; the remainder is zero-padded by the consumer.
REQ-016 tile_first_k, tile_last_k  out  1 each  first_k means clear the accumulator; last_k means write C after this tile.
REQ-017 a_addr, b_addr, c_addr  out  ADDRESS_SIZE each  tile-origin addresses.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, CHECK, ISSUE, FINISH.
REQ-019 IDLE, start=1: latch all sizes and offsets, clear size_error, go to CHECK; busy=1 from the next cycle.
REQ-020 Start SHALL be ignored in every state other than IDLE.
REQ-021 CHECK, any size equal to 0: set size_error and go to FINISH; no tile is issued.
REQ-022 CHECK, otherwise: zero all indices and go to ISSUE.
REQ-023 ISSUE: tile_stb=1, and every tile_* and *_addr output SHALL be held stable until the cycle tile_ack=1.
REQ-024 Tile order SHALL be: tile_row outer, tile_col middle, tile_k inner, each stepping by 4 while index < size.
REQ-025 On tile_ack for a non-final tile, the next tile SHALL be presented in the following cycle with tile_stb kept high (back-to-back, zero bubble).
REQ-026 On tile_ack for the final tile, go to FINISH with tile_stb=0 in the following cycle.
REQ-027 FINISH: done=1 for exactly one cycle and busy=0, then go to IDLE; size_error SHALL hold until the next accepted start.
REQ-028 rows_valid SHALL equal min(4, m_size - tile_row); cols_valid and k_valid SHALL follow the same rule with n_size/tile_col and k_size/tile_k.
REQ-029 tile_first_k SHALL be 1 when tile_k = 0.
REQ-030 tile_last_k SHALL be 1 when tile_k + 4 >= k_size.
REQ-031 a_addr SHALL equal a_offset + tile_row*k_size + tile_k.
REQ-032 b_addr SHALL equal b_offset + tile_k*n_size + tile_col.
REQ-033 c_addr SHALL equal c_offset + tile_row*n_size + tile_col.
REQ-034 Address products SHALL be computed at 2*DIM_W bits, summed, then truncated to ADDRESS_SIZE; wrap-around is permitted and not flagged.
REQ-035 Total tiles issued SHALL equal ceil(m/4)*ceil(n/4)*ceil(k/4).
REQ-036 Index comparisons SHALL be done at DIM_W+1 bits so that an index step past 2^DIM_W-4 cannot wrap.

Reset
REQ-037 With reset=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-ISSUE with tile_stb high.
REQ-038 All outputs SHALL reset to 0.
REQ-039 The latched configuration SHALL reset to 0.
REQ-040 tile_ack during reset SHALL be ignored.

Structure
REQ-041 Shared package mm_pkg SHALL hold: the FSM state encoding, TILE_DIM=4, the default ADDRESS_SIZE, and the address-calculation function.
REQ-042 One sub-module, tile_addr_gen, SHALL be used: combinational, mapping the indices and latched configuration to the three addresses and the valid extents.
REQ-043 The index counters and FSM SHALL live in tile_scheduler.

Verification
REQ-044 m=k=n=4, offsets 0/16/32, ack every cycle -> one tile (0,0,0): first_k=1, last_k=1, valids 4/4/4, addrs 0/16/32; done 1 cycle later.
REQ-045 m=8,k=8,n=4, ack always high -> 4 tiles in order (r,c,k) = (0,0,0),(0,0,4),(4,0,0),(4,0,4) on consecutive cycles; last_k high on the 2nd and 4th tiles.
REQ-046 m=5,k=3,n=6 -> 4 tiles; tile (4,4,0): rows_valid=1, cols_valid=2, k_valid=3, a_addr=a_offset+12, c_addr=c_offset+28.
REQ-047 k_size=0 -> no tile_stb; size_error=1; done pulse 2 cycles after start; a new valid start clears size_error.
REQ-048 tile_ack held low for 5 cycles during the 2nd tile -> outputs stable throughout; a start pulsed meanwhile is ignored.
REQ-049 reset asserted mid-ISSUE -> next cycle tile_stb=0, busy=0, state IDLE; a fresh start reruns the job from tile (0,0,0).

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the tile scheduler: FSM encoding, tile geometry,
// default address width and the tile-origin address arithmetic.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam int TILE_DIM             = 4;
    localparam int DEFAULT_ADDRESS_SIZE = 8;

    // Wide enough for any DIM_W <= 16 product plus offset; callers truncate
    // the result to their address width, so wrap-around falls out naturally.
    localparam int CALC_W = 32;

    // base + idx_major * stride + idx_minor, as used for the row-major A, B and C.
    function automatic logic [CALC_W-1:0] tile_origin_addr(
        input logic [CALC_W-1:0] base,
        input logic [CALC_W-1:0] idx_major,
        input logic [CALC_W-1:0] stride,
        input logic [CALC_W-1:0] idx_minor
    );
        return base + idx_major * stride + idx_minor;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Combinational mapping from the current tile indices and the latched job
// configuration to the three tile-origin addresses and the valid extents.
module tile_addr_gen
    import mm_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int DIM_W        = 8
) (
    input  logic [DIM_W-1:0]        tile_row_i,
    input  logic [DIM_W-1:0]        tile_col_i,
    input  logic [DIM_W-1:0]        tile_k_i,
    input  logic [DIM_W-1:0]        m_size_i,
    input  logic [DIM_W-1:0]        k_size_i,
    input  logic [DIM_W-1:0]        n_size_i,
    input  logic [ADDRESS_SIZE-1:0] a_offset_i,
    input  logic [ADDRESS_SIZE-1:0] b_offset_i,
    input  logic [ADDRESS_SIZE-1:0] c_offset_i,
    output logic [ADDRESS_SIZE-1:0] a_addr_o,
    output logic [ADDRESS_SIZE-1:0] b_addr_o,
    output logic [ADDRESS_SIZE-1:0] c_addr_o,
    output logic [2:0]              rows_valid_o,
    output logic [2:0]              cols_valid_o,
    output logic [2:0]              k_valid_o
);

    // A is m x k, B is k x n, C is m x n, all row-major.
    assign a_addr_o = ADDRESS_SIZE'(tile_origin_addr(CALC_W'(a_offset_i), CALC_W'(tile_row_i),
                                                     CALC_W'(k_size_i), CALC_W'(tile_k_i)));
    assign b_addr_o = ADDRESS_SIZE'(tile_origin_addr(CALC_W'(b_offset_i), CALC_W'(tile_k_i),
                                                     CALC_W'(n_size_i), CALC_W'(tile_col_i)));
    assign c_addr_o = ADDRESS_SIZE'(tile_origin_addr(CALC_W'(c_offset_i), CALC_W'(tile_row_i),
                                                     CALC_W'(n_size_i), CALC_W'(tile_col_i)));

    // Lane 0 = rows (m), lane 1 = cols (n), lane 2 = k.
    logic [2:0][DIM_W-1:0] size_v;
    logic [2:0][DIM_W-1:0] idx_v;
    logic [2:0][2:0]       ext_v;

    assign size_v[0] = m_size_i;
    assign size_v[1] = n_size_i;
    assign size_v[2] = k_size_i;
    assign idx_v[0]  = tile_row_i;
    assign idx_v[1]  = tile_col_i;
    assign idx_v[2]  = tile_k_i;

    // Extent = min(TILE_DIM, size - index), computed one bit wider so a
    // stale index beyond the size saturates to a full tile instead of wrapping small.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_extent
            logic [DIM_W:0] remain;
            assign remain    = {1'b0, size_v[gi]} - {1'b0, idx_v[gi]};
            assign ext_v[gi] = (remain >= (DIM_W+1)'(TILE_DIM)) ? 3'(TILE_DIM) : remain[2:0];
        end
    endgenerate

    assign rows_valid_o = ext_v[0];
    assign cols_valid_o = ext_v[1];
    assign k_valid_o    = ext_v[2];

endmodule

// File: rtl/tile_scheduler.sv
// Walks an m x k by k x n matrix multiply as 4x4x4 tiles (row outer, col
// middle, k inner) and hands each tile to a consumer over a stb/ack handshake.
module tile_scheduler
    import mm_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int DIM_W        = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DIM_W-1:0]        m_size,
    input  logic [DIM_W-1:0]        k_size,
    input  logic [DIM_W-1:0]        n_size,
    input  logic [ADDRESS_SIZE-1:0] a_offset,
    input  logic [ADDRESS_SIZE-1:0] b_offset,
    input  logic [ADDRESS_SIZE-1:0] c_offset,
    output logic                    busy,
    output logic                    done,
    output logic                    size_error,
    output logic                    tile_stb,
    input  logic                    tile_ack,
    output logic [DIM_W-1:0]        tile_row,
    output logic [DIM_W-1:0]        tile_col,
    output logic [DIM_W-1:0]        tile_k,
    output logic [2:0]              rows_valid,
    output logic [2:0]              cols_valid,
    output logic [2:0]              k_valid,
    output logic                    tile_first_k,
    output logic                    tile_last_k,
    output logic [ADDRESS_SIZE-1:0] a_addr,
    output logic [ADDRESS_SIZE-1:0] b_addr,
    output logic [ADDRESS_SIZE-1:0] c_addr
);

    localparam logic [DIM_W:0] STEP = (DIM_W+1)'(TILE_DIM);

    state_e                  state_q, state_d;
    logic [DIM_W-1:0]        m_size_q, m_size_d;
    logic [DIM_W-1:0]        k_size_q, k_size_d;
    logic [DIM_W-1:0]        n_size_q, n_size_d;
    logic [ADDRESS_SIZE-1:0] a_offset_q, a_offset_d;
    logic [ADDRESS_SIZE-1:0] b_offset_q, b_offset_d;
    logic [ADDRESS_SIZE-1:0] c_offset_q, c_offset_d;
    logic [DIM_W-1:0]        row_q, row_d;
    logic [DIM_W-1:0]        col_q, col_d;
    logic [DIM_W-1:0]        kidx_q, kidx_d;
    logic                    size_error_q, size_error_d;

    // Index steps are one bit wider so stepping past 2^DIM_W-4 cannot wrap below the size.
    logic [DIM_W:0] row_step, col_step, kidx_step;
    logic           row_more, col_more, kidx_more;

    assign row_step  = {1'b0, row_q}  + STEP;
    assign col_step  = {1'b0, col_q}  + STEP;
    assign kidx_step = {1'b0, kidx_q} + STEP;
    assign row_more  = row_step  < {1'b0, m_size_q};
    assign col_more  = col_step  < {1'b0, n_size_q};
    assign kidx_more = kidx_step < {1'b0, k_size_q};

    // State, latched job configuration and tile indices.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            m_size_q     <= '0;
            k_size_q     <= '0;
            n_size_q     <= '0;
            a_offset_q   <= '0;
            b_offset_q   <= '0;
            c_offset_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            kidx_q       <= '0;
            size_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_size_q     <= m_size_d;
            k_size_q     <= k_size_d;
            n_size_q     <= n_size_d;
            a_offset_q   <= a_offset_d;
            b_offset_q   <= b_offset_d;
            c_offset_q   <= c_offset_d;
            row_q        <= row_d;
            col_q        <= col_d;
            kidx_q       <= kidx_d;
            size_error_q <= size_error_d;
        end
    end

    // Next-state: accept a job, validate sizes, then advance k, col, row on each ack.
    always_comb begin
        state_d      = state_q;
        m_size_d     = m_size_q;
        k_size_d     = k_size_q;
        n_size_d     = n_size_q;
        a_offset_d   = a_offset_q;
        b_offset_d   = b_offset_q;
        c_offset_d   = c_offset_q;
        row_d        = row_q;
        col_d        = col_q;
        kidx_d       = kidx_q;
        size_error_d = size_error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_size_d     = m_size;
                    k_size_d     = k_size;
                    n_size_d     = n_size;
                    a_offset_d   = a_offset;
                    b_offset_d   = b_offset;
                    c_offset_d   = c_offset;
                    size_error_d = 1'b0;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                row_d  = '0;
                col_d  = '0;
                kidx_d = '0;
                if (m_size_q == '0 || k_size_q == '0 || n_size_q == '0) begin
                    size_error_d = 1'b1;
                    state_d      = ST_FINISH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tile_ack) begin
                    if (kidx_more) begin
                        kidx_d = kidx_step[DIM_W-1:0];
                    end else begin
                        kidx_d = '0;
                        if (col_more) begin
                            col_d = col_step[DIM_W-1:0];
                        end else begin
                            col_d = '0;
                            if (row_more) begin
                                row_d = row_step[DIM_W-1:0];
                            end else begin
                                row_d   = '0;
                                state_d = ST_FINISH;
                            end
                        end
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign busy         = (state_q == ST_CHECK) || (state_q == ST_ISSUE);
    assign done         = (state_q == ST_FINISH);
    assign size_error   = size_error_q;
    assign tile_stb     = (state_q == ST_ISSUE);
    assign tile_row     = row_q;
    assign tile_col     = col_q;
    assign tile_k       = kidx_q;
    // Flags are qualified by the strobe so they read 0 whenever no tile is offered.
    assign tile_first_k = tile_stb && (kidx_q == '0);
    assign tile_last_k  = tile_stb && !kidx_more;

    tile_addr_gen #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .DIM_W        (DIM_W)
    ) u_addr_gen (
        .tile_row_i   (row_q),
        .tile_col_i   (col_q),
        .tile_k_i     (kidx_q),
        .m_size_i     (m_size_q),
        .k_size_i     (k_size_q),
        .n_size_i     (n_size_q),
        .a_offset_i   (a_offset_q),
        .b_offset_i   (b_offset_q),
        .c_offset_i   (c_offset_q),
        .a_addr_o     (a_addr),
        .b_addr_o     (b_addr),
        .c_addr_o     (c_addr),
        .rows_valid_o (rows_valid),
        .cols_valid_o (cols_valid),
        .k_valid_o    (k_valid)
    );

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: directed jobs plus random jobs,
// each tile compared against a loop-nest reference model of the tile walk.
module tb_tile_scheduler;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] m_size = '0, k_size = '0, n_size = '0;
    logic [AW-1:0] a_offset = '0, b_offset = '0, c_offset = '0;
    logic          tile_ack = 1'b0;
    logic          busy, done, size_error, tile_stb;
    logic [DW-1:0] tile_row, tile_col, tile_k;
    logic [2:0]    rows_valid, cols_valid, k_valid;
    logic          tile_first_k, tile_last_k;
    logic [AW-1:0] a_addr, b_addr, c_addr;

    tile_scheduler #(.ADDRESS_SIZE(AW), .DIM_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .m_size(m_size), .k_size(k_size), .n_size(n_size),
        .a_offset(a_offset), .b_offset(b_offset), .c_offset(c_offset),
        .busy(busy), .done(done), .size_error(size_error),
        .tile_stb(tile_stb), .tile_ack(tile_ack),
        .tile_row(tile_row), .tile_col(tile_col), .tile_k(tile_k),
        .rows_valid(rows_valid), .cols_valid(cols_valid), .k_valid(k_valid),
        .tile_first_k(tile_first_k), .tile_last_k(tile_last_k),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] row, col, k;
        logic [2:0]    rv, cv, kv;
        logic          first, last;
        logic [AW-1:0] a, b, c;
    } tile_t;

    tile_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic tile_t observed();
        tile_t t;
        t.row = tile_row; t.col = tile_col; t.k = tile_k;
        t.rv = rows_valid; t.cv = cols_valid; t.kv = k_valid;
        t.first = tile_first_k; t.last = tile_last_k;
        t.a = a_addr; t.b = b_addr; t.c = c_addr;
        return t;
    endfunction

    function automatic int ext(input int size, input int idx);
        return (size - idx >= 4) ? 4 : size - idx;
    endfunction

    // Reference: the plain triple loop over tile origins with the address formulas.
    task automatic build_model(input int m, k, n, ao, bo, co);
        tile_t t;
        exp_q.delete();
        for (int r = 0; r < m; r += 4)
            for (int c = 0; c < n; c += 4)
                for (int kk = 0; kk < k; kk += 4) begin
                    t.row = DW'(r); t.col = DW'(c); t.k = DW'(kk);
                    t.rv = 3'(ext(m, r)); t.cv = 3'(ext(n, c)); t.kv = 3'(ext(k, kk));
                    t.first = (kk == 0);
                    t.last  = (kk + 4 >= k);
                    t.a = AW'((ao + r * k + kk) % (1 << AW));
                    t.b = AW'((bo + kk * n + c) % (1 << AW));
                    t.c = AW'((co + r * n + c) % (1 << AW));
                    exp_q.push_back(t);
                end
    endtask

    // mode 0: ack every cycle; 1: random ack; 2: stall 5 cycles on the 2nd tile with a stray start.
    task automatic run_job(input int m, k, n, ao, bo, co, input int mode);
        int cyc, accepted, stall, n_exp;
        build_model(m, k, n, ao, bo, co);
        n_exp = exp_q.size();
        m_size = DW'(m); k_size = DW'(k); n_size = DW'(n);
        a_offset = AW'(ao); b_offset = AW'(bo); c_offset = AW'(co);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("stb_in_check", tile_stb, 0);
        chk("err_cleared", size_error, 0);
        tick();
        if (m == 0 || k == 0 || n == 0) begin
            chk("err_done", done, 1);
            chk("err_flag", size_error, 1);
            chk("err_no_stb", tile_stb, 0);
            chk("err_busy", busy, 0);
            tick();
            chk("err_done_gone", done, 0);
            chk("err_flag_hold", size_error, 1);
            chk("err_no_stb2", tile_stb, 0);
            $display("job m=%0d k=%0d n=%0d size_error job finished", m, k, n);
            return;
        end
        cyc = 0; accepted = 0; stall = 0;
        while (exp_q.size() > 0 && cyc < 1000) begin
            start = 1'b0;
            chk("stb_high", tile_stb, 1);
            chk($sformatf("tile%0d", accepted), observed(), exp_q[0]);
            case (mode)
                1: tile_ack = 1'($urandom_range(0, 1));
                2: begin
                    if (accepted == 1 && stall < 5) begin
                        tile_ack = 1'b0;
                        stall++;
                        if (stall == 2) begin
                            start = 1'b1;
                            m_size = 8'd1; k_size = 8'd0; n_size = 8'd1;
                            a_offset = 8'hAA;
                        end
                    end else begin
                        tile_ack = 1'b1;
                    end
                end
                default: tile_ack = 1'b1;
            endcase
            tick();
            if (tile_ack) begin
                void'(exp_q.pop_front());
                accepted++;
            end
            cyc++;
        end
        tile_ack = 1'b0;
        start    = 1'b0;
        chk("tiles_left", exp_q.size(), 0);
        chk("tiles_accepted", accepted, n_exp);
        if (mode == 0) chk("cycles_b2b", cyc, n_exp);
        chk("fin_done", done, 1);
        chk("fin_stb", tile_stb, 0);
        chk("fin_busy", busy, 0);
        chk("fin_err", size_error, 0);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        $display("job m=%0d k=%0d n=%0d mode=%0d tiles=%0d cycles=%0d", m, k, n, mode, accepted, cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with ack high: ack must be ignored and all outputs zero.
        reset = 1'b1; tile_ack = 1'b1;
        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stb", tile_stb, 0);
        chk("reset_outs", {busy, done, size_error, tile_stb, tile_row, tile_col, tile_k,
                           rows_valid, cols_valid, k_valid, tile_first_k, tile_last_k,
                           a_addr, b_addr, c_addr}, 0);
        reset = 1'b0; tile_ack = 1'b0;
        tick();

        run_job(4, 4, 4, 0, 16, 32, 0);
        run_job(8, 8, 4, 3, 100, 200, 0);
        run_job(5, 3, 6, 10, 20, 30, 0);
        run_job(5, 0, 6, 1, 2, 3, 0);
        run_job(4, 4, 4, 7, 8, 9, 0);
        run_job(8, 8, 4, 1, 2, 3, 2);

        // Reset in the middle of ISSUE with the strobe high and ack asserted.
        m_size = 8'd8; k_size = 8'd8; n_size = 8'd8;
        a_offset = 8'd5; b_offset = 8'd6; c_offset = 8'd7;
        start = 1'b1; tick(); start = 1'b0; tick();
        tile_ack = 1'b1; tick();
        chk("pre_reset_stb", tile_stb, 1);
        reset = 1'b1; tick();
        chk("midreset_stb", tile_stb, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_outs", {done, size_error, tile_row, tile_col, tile_k,
                              rows_valid, a_addr, b_addr, c_addr}, 0);
        reset = 1'b0; tile_ack = 1'b0;
        tick();
        chk("post_reset_idle", {busy, tile_stb}, 0);
        $display("mid-issue reset applied");
        run_job(8, 8, 8, 5, 6, 7, 0);

        // Index-width boundaries and address wrap-around.
        run_job(255, 1, 1, 250, 251, 252, 0);
        run_job(1, 255, 2, 200, 9, 0, 1);
        run_job(253, 2, 3, 255, 255, 255, 1);

        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
                    int'($urandom_range(1, 13)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
